// File: rtl/rgb_mixer_pkg.sv
// Purpose: constants and decode helpers shared by the RGB mixer encoder and PWM stages.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// ENC_WIDTH is also imported by the PWM stage, so position and duty-cycle widths cannot drift apart.
package rgb_mixer_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int ENC_WIDTH        = 8;
    localparam int ENC_DEBOUNCE_LEN = 8;

    // Result of comparing the debounced A/B levels with their previous-cycle copies.
    //   vld    : a single A edge occurred, so the position moves by one
    //   up     : direction of that move (DIR_UP / DIR_DOWN)
    //   glitch : A and B moved together, so the direction is ambiguous and the edge is discarded
    typedef struct packed {
        logic vld;
        logic up;
        logic glitch;
    } quad_dec_t;

    // Only A edges are counted; B merely qualifies the direction. This gives
    // two counts per full quadrature cycle (00 -> 10 -> 11 -> 01 -> 00).
    // After an A edge, A and B differ when the shaft turns clockwise:
    //   A rising with B low, or A falling with B high.
    function automatic quad_dec_t quad_decode(
        input logic a_db,
        input logic a_q,
        input logic b_db,
        input logic b_q
    );
        quad_dec_t dec;
        logic      a_chg;
        logic      b_chg;

        a_chg      = a_db ^ a_q;
        b_chg      = b_db ^ b_q;
        dec.vld    = a_chg & ~b_chg;
        dec.up     = (a_db ^ b_db) ? DIR_UP : DIR_DOWN;
        dec.glitch = a_chg & b_chg;
        return dec;
    endfunction

endpackage

// File: rtl/quad_encoder_counter_debounce.sv
// Purpose: 2-flop synchroniser plus majority-free (all-agree) debounce filter for one raw pad input.
// Latency: a clean level change reaches out after DEBOUNCE_LEN+2 rising edges.
// Backpressure: none; free-running filter, samples every cycle.
//
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   in           : raw pad level, asynchronous to clk, may bounce
//   out          : debounced level; changes only after DEBOUNCE_LEN agreeing samples
module debounce #(
    parameter int DEBOUNCE_LEN = 8          // must be >= 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in,
    output logic out
);

    logic                    sync_1;
    logic                    sync_2;
    // Older DEBOUNCE_LEN-1 samples; together with sync_2 they form the
    // DEBOUNCE_LEN-sample window. Folding sync_2 into the window (rather than
    // waiting for it to enter the shift register) saves one cycle of latency.
    logic [DEBOUNCE_LEN-2:0] hist;
    logic [DEBOUNCE_LEN-2:0] hist_nxt;
    logic                    all_hi;
    logic                    all_lo;

    always_comb begin
        hist_nxt    = hist << 1;
        hist_nxt[0] = sync_2;
    end

    assign all_hi = sync_2 & (&hist);
    assign all_lo = ~sync_2 & ~(|hist);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            hist   <= '0;
            out    <= 1'b0;
        end else begin
            sync_1 <= in;
            sync_2 <= sync_1;
            hist   <= hist_nxt;
            // A mixed window means the pad is still bouncing: hold the old level.
            if (all_hi) begin
                out <= 1'b1;
            end else if (all_lo) begin
                out <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/quad_encoder_counter.sv
// Purpose: debounced quadrature decoder producing a WIDTH-bit position (PWM duty cycle) for one encoder.
// Latency: pad edge to value/step/dir is DEBOUNCE_LEN+3 cycles; clear acts at the next edge.
// Backpressure: none; every decoded edge is applied immediately, edges closer than DEBOUNCE_LEN cycles are dropped.
//
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   enc_a, enc_b : raw encoder pads, asynchronous, may bounce
//   clear        : synchronous position reset, wins over a same-cycle step
//   value        : registered position
//   step         : one-cycle pulse per commanded move (also when clamped at a bound)
//   dir          : direction of the last move (1 = up), held between moves
//   glitch       : one-cycle pulse when A and B change in the same cycle
module quad_encoder_counter
    import rgb_mixer_pkg::*;
#(
    parameter int WIDTH        = ENC_WIDTH,
    parameter int DEBOUNCE_LEN = ENC_DEBOUNCE_LEN,
    parameter int SATURATE     = 0              // 0 = wrap modulo 2^WIDTH, 1 = clamp at the bounds
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             step,
    output logic             dir,
    output logic             glitch
);

    localparam bit               SAT_EN    = (SATURATE != 0);
    localparam logic [WIDTH-1:0] VALUE_MAX = '1;
    localparam logic [WIDTH-1:0] VALUE_MIN = '0;
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic             a_db;
    logic             b_db;
    logic             a_q;
    logic             b_q;
    quad_dec_t        dec;
    logic [WIDTH-1:0] value_nxt;

    debounce #(
        .DEBOUNCE_LEN (DEBOUNCE_LEN)
    ) u_db_a (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (enc_a),
        .out     (a_db)
    );

    debounce #(
        .DEBOUNCE_LEN (DEBOUNCE_LEN)
    ) u_db_b (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (enc_b),
        .out     (b_db)
    );

    assign dec = quad_decode(a_db, a_q, b_db, b_q);

    // Saturating mode keeps the value pinned at the bound; the step pulse and
    // direction still report the user's intent so the UI can react to it.
    always_comb begin
        value_nxt = value;
        if (dec.up == DIR_UP) begin
            if (!(SAT_EN && (value == VALUE_MAX))) begin
                value_nxt = value + ONE;
            end
        end else begin
            if (!(SAT_EN && (value == VALUE_MIN))) begin
                value_nxt = value - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            value  <= '0;
            step   <= 1'b0;
            dir    <= DIR_DOWN;
            glitch <= 1'b0;
        end else begin
            a_q    <= a_db;
            b_q    <= b_db;
            glitch <= dec.glitch;
            if (clear) begin
                // The edge that coincides with clear is swallowed entirely,
                // including its direction, so dir keeps its previous value.
                value <= '0;
                step  <= 1'b0;
            end else if (dec.vld) begin
                value <= value_nxt;
                step  <= 1'b1;
                dir   <= dec.up;
            end else begin
                step  <= 1'b0;
            end
        end
    end

endmodule
